riscv_prefetch_fifo_buffer: RTL and testbench
=============================================

Name: riscv_prefetch_fifo_buffer

Overview:
Instruction prefetcher between the instruction memory/cache port and the IF stage offset FSM. It issues word-aligned fetches, buffers returned words in a small FIFO, and realigns them so every output word starts at the current PC, which may be halfword-aligned. It also handles branch/hwloop redirects with in-flight response discard, and PMP fetch faults. The compressed decoder in IF consumes rdata_o directly.

Parameters:
DEPTH, 3, FIFO entries (32-bit words); legal 2..8.
RDATA_WIDTH, 32, memory data width; only 32 supported.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_i  in  1  fetching enabled; when low, no new memory requests issue
branch_i  in  1  redirect to addr_i (one-cycle pulse)
addr_i  in  32  redirect target, bit0 always 0
hwloop_i  in  1  hwloop jump to hwloop_target_i
hwloop_target_i  in  32  hwloop target, bit0 always 0
hwlp_branch_o  out  1  hwloop redirect taken this cycle
ready_i  in  1  IF consumes current instruction
valid_o  out  1  rdata_o/addr_o hold a complete instruction
rdata_o  out  32  instruction, aligned to addr_o
addr_o  out  32  PC of rdata_o
is_hwlp_o  out  1  current instruction is a hwloop target
instr_req_o  out  1  memory request
instr_addr_o  out  32  word address, bits[1:0]=0
instr_gnt_i  in  1  request accepted
instr_rvalid_i  in  1  response valid
instr_rdata_i  in  32  response data
instr_err_pmp_i  in  1  PMP denies the current request
fetch_failed_o  out  1  fetch fault pending
busy_o  out  1  request or response outstanding

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM IDLE; addr_o=0.
- Memory FSM states: IDLE, WAIT_GNT, WAIT_RVALID, WAIT_ABORTED, FAILED. At most one outstanding transaction.
- IDLE: if req_i and FIFO has a free slot, assert instr_req_o. Next state is WAIT_RVALID on gnt, else WAIT_GNT.
- WAIT_GNT: instr_req_o and instr_addr_o are held stable until gnt; a redirect does not change them here.
- WAIT_RVALID: on rvalid, push data. The next request may issue in the same cycle, subject to the free-slot rule, where free slots exclude the outstanding slot.
- Redirect (branch_i or hwloop_i) with a granted-but-unreturned or ungranted request in flight: go to WAIT_ABORTED. The stale rvalid is dropped, then fetch restarts at the new target's word.
- Redirect effect: FIFO flushed in the same cycle; addr_o <= target. Fetch address <= {target[31:2],2'b00}.
- branch_i has priority over hwloop_i when both are asserted. hwlp_branch_o=1 only when hwloop_i is accepted, meaning no branch_i and not FAILED. is_hwlp_o=1 for the first instruction after a hwloop redirect, cleared on its consumption.
- PMP fault: instr_req_o && instr_err_pmp_i, no grant. Request drops next cycle; FSM enters FAILED; fetch_failed_o=1. Only branch_i leaves FAILED; its target refetch then proceeds as normal.
- Word fetch address increments by 4 per issued request, wrapping at 2^32.
- Aligner, addr_o[1]=0:
  - rdata_o=fifo[0]; valid_o when FIFO non-empty.
- Aligner, addr_o[1]=1:
  - Lower half h=fifo[0][31:16].
  - If h[1:0]!=2'b11 (compressed): valid_o with one entry; rdata_o={16'h0,h}.
  - Otherwise: valid_o needs two entries; rdata_o={fifo[1][15:0],h}.
- Response bypass: a word arriving on rvalid while the FIFO is empty is visible on rdata_o in the same cycle (zero-latency).
- Consumption (valid_o && ready_i): addr_o += 2 if rdata_o[1:0]!=2'b11, else +4. Pop fifo[0] when the new addr_o crosses a word boundary.
- Simultaneous push+pop allowed; full FIFO with pop frees the slot for a same-cycle request.
- valid_o=0 in the cycle of a redirect and in FAILED.
- busy_o=1 in WAIT_GNT, WAIT_RVALID, WAIT_ABORTED.
- Mid-operation reset: immediate return to reset state; no memory handshake guarantee.
- Protocol: gnt without req is ignored. rvalid in IDLE or FAILED is ignored.

Decomposition:
- Shared package riscv_defines: prefetch FSM state enum (prefetch_fsm_e) and the compressed-detect helper constant (2'b11 opcode marker).
- One sub-module: riscv_fetch_fifo. It holds DEPTH x 32 data plus valid bits, with push, pop, flush, empty/full/count, and first two entries exposed.
- Aligner and memory FSM stay in the top module.

Test Plan:
- Boot, branch_i to 0x100, memory returns 0x00000013, 0x00100093 with 1-cycle gnt/rvalid → valid_o with addr_o 0x100 then 0x104, rdata_o matching; instr_addr_o 0x100, 0x104, 0x108.
- branch_i to 0x202, word@0x200=0x4505_0001 → rdata_o=0x00004505, valid_o with one entry, addr_o 0x202 then 0x204 after consume.
- branch_i to 0x302, words 0x0513_xxxx, 0x0000_0005 → valid_o only after second word; rdata_o=0x00050513, addr_o then 0x306.
- branch_i to 0x400 while request to 0x100 granted but rvalid pending → stale rvalid dropped; first valid_o carries addr_o 0x400 with word@0x400.
- ready_i=0 for 10 cycles → exactly DEPTH words buffered, instr_req_o deasserted; one consume → exactly one new request issued.
- instr_err_pmp_i=1 on request to 0x500 → fetch_failed_o=1, valid_o=0, no gnt; branch_i to 0x80 → fetch_failed_o=0, fetch resumes at 0x80.

Source files
------------

// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - prefetch FSM states and compressed-instruction helper
package riscv_defines;

   typedef enum logic [2:0] {
      PF_IDLE,
      PF_WAIT_GNT,
      PF_WAIT_RVALID,
      PF_WAIT_ABORTED,
      PF_FAILED
   } prefetch_fsm_e;

   localparam logic [1:0] OPCODE_FULL = 2'b11;

   function automatic logic is_compressed(input logic [15:0] parcel);
      return parcel[1:0] != OPCODE_FULL;
   endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// rtl/riscv_fetch_fifo.sv - word FIFO for fetched instructions, head entries exposed
module riscv_fetch_fifo #(
   parameter int DEPTH = 3,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic [31:0]   wdata,
   input  logic          pop,
   output logic [31:0]   rdata0,
   output logic [15:0]   rdata1_lo,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);

   logic [DEPTH-1:0][31:0] data_q, data_n;
   logic [DEPTH-1:0]       valid_q, valid_n;
   logic                   placed;

   always_comb begin
      data_n  = data_q;
      valid_n = valid_q;
      placed  = 1'b0;
      if (pop) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            data_n[i]  = data_q[i+1];
            valid_n[i] = valid_q[i+1];
         end
         valid_n[DEPTH-1] = 1'b0;
      end
      // push+pop while empty: the word was consumed straight off the bypass
      if (push && !(pop && !valid_q[0])) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (!placed && !valid_n[i]) begin
               data_n[i]  = wdata;
               valid_n[i] = 1'b1;
               placed     = 1'b1;
            end
         end
      end
      if (flush) valid_n = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= '0;
      else        valid_q <= valid_n;
   end

   always_ff @(posedge clk) begin
      data_q <= data_n;
   end

   always_comb begin
      count = '0;
      for (int i = 0; i < DEPTH; i++) count = count + CW'(valid_q[i]);
   end

   assign rdata0    = data_q[0];
   assign rdata1_lo = data_q[1][15:0];
   assign empty     = !valid_q[0];
   assign full      = valid_q[DEPTH-1];

endmodule

// File: rtl/riscv_prefetch_fifo_buffer.sv
// rtl/riscv_prefetch_fifo_buffer.sv - instruction prefetcher with realigning output
module riscv_prefetch_fifo_buffer
   import riscv_defines::*;
#(
   parameter int DEPTH       = 3,
   parameter int RDATA_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_i,
   input  logic                   branch_i,
   input  logic [31:0]            addr_i,
   input  logic                   hwloop_i,
   input  logic [31:0]            hwloop_target_i,
   output logic                   hwlp_branch_o,
   input  logic                   ready_i,
   output logic                   valid_o,
   output logic [31:0]            rdata_o,
   output logic [31:0]            addr_o,
   output logic                   is_hwlp_o,
   output logic                   instr_req_o,
   output logic [31:0]            instr_addr_o,
   input  logic                   instr_gnt_i,
   input  logic                   instr_rvalid_i,
   input  logic [RDATA_WIDTH-1:0] instr_rdata_i,
   input  logic                   instr_err_pmp_i,
   output logic                   fetch_failed_o,
   output logic                   busy_o
);

   localparam int CW = $clog2(DEPTH + 1);

   prefetch_fsm_e state_q, state_d;
   logic [31:0]   fetch_addr_q, req_addr_q, addr_q, target, addr_next;
   logic          abt_gnt_q, abt_gnt_d, is_hwlp_q;
   logic          hwlp_acc, redirect, resp, push, pop, consume;
   logic          slot_free, can_issue, issue, aligned_valid;
   logic [31:0]   fifo_rdata0, view0;
   logic [15:0]   fifo_rdata1_lo, view1_lo, half;
   logic [CW-1:0] fifo_count, avail;
   logic          fifo_empty, fifo_full;

   assign hwlp_acc = hwloop_i && !branch_i && (state_q != PF_FAILED);
   assign redirect = branch_i || hwlp_acc;
   assign target   = branch_i ? addr_i : hwloop_target_i;
   assign resp     = (state_q == PF_WAIT_RVALID) && instr_rvalid_i;
   assign push     = resp && !redirect;

   riscv_fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect),
      .push      (push),
      .wdata     (instr_rdata_i),
      .pop       (pop),
      .rdata0    (fifo_rdata0),
      .rdata1_lo (fifo_rdata1_lo),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   // a response landing in an empty FIFO is presented the same cycle
   assign view0    = fifo_empty ? instr_rdata_i : fifo_rdata0;
   assign view1_lo = (fifo_count >= CW'(2)) ? fifo_rdata1_lo : instr_rdata_i[15:0];
   assign avail    = fifo_count + CW'(push);
   assign half     = view0[31:16];

   always_comb begin
      aligned_valid = 1'b0;
      rdata_o       = view0;
      if (!addr_q[1]) begin
         aligned_valid = (avail != '0);
      end else if (is_compressed(half)) begin
         aligned_valid = (avail != '0);
         rdata_o       = {16'h0000, half};
      end else begin
         aligned_valid = (avail >= CW'(2));
         rdata_o       = {view1_lo, half};
      end
   end

   assign valid_o   = aligned_valid && !redirect && (state_q != PF_FAILED);
   assign consume   = valid_o && ready_i;
   assign addr_next = addr_q + (is_compressed(rdata_o[15:0]) ? 32'd2 : 32'd4);
   assign pop       = consume && (addr_next[31:2] != addr_q[31:2]);

   // a returning word still needs its slot, so it counts against the space
   assign slot_free = pop || (resp ? (fifo_count < CW'(DEPTH - 1)) : !fifo_full);
   assign can_issue = req_i && !redirect && slot_free;

   always_comb begin
      state_d      = state_q;
      abt_gnt_d    = abt_gnt_q;
      instr_req_o  = 1'b0;
      instr_addr_o = fetch_addr_q;
      issue        = 1'b0;
      case (state_q)
         PF_IDLE: issue = can_issue;
         PF_WAIT_GNT: begin
            instr_req_o  = 1'b1;
            instr_addr_o = req_addr_q;
            if (instr_err_pmp_i)  state_d = redirect ? PF_IDLE : PF_FAILED;
            else if (redirect) begin
               state_d   = PF_WAIT_ABORTED;
               abt_gnt_d = instr_gnt_i;
            end else if (instr_gnt_i) state_d = PF_WAIT_RVALID;
         end
         PF_WAIT_RVALID: begin
            if (instr_rvalid_i) begin
               issue = can_issue;
               if (!can_issue) state_d = PF_IDLE;
            end else if (redirect) begin
               state_d   = PF_WAIT_ABORTED;
               abt_gnt_d = 1'b1;
            end
         end
         PF_WAIT_ABORTED: begin
            if (!abt_gnt_q) begin
               instr_req_o  = 1'b1;
               instr_addr_o = req_addr_q;
               if (instr_err_pmp_i)  state_d   = PF_IDLE;
               else if (instr_gnt_i) abt_gnt_d = 1'b1;
            end else if (instr_rvalid_i) begin
               state_d = PF_IDLE;
            end
         end
         PF_FAILED: if (branch_i) state_d = PF_IDLE;
         default:   state_d = PF_IDLE;
      endcase
      if (issue) begin
         instr_req_o  = 1'b1;
         instr_addr_o = fetch_addr_q;
         if (instr_err_pmp_i)  state_d = PF_FAILED;
         else if (instr_gnt_i) state_d = PF_WAIT_RVALID;
         else                  state_d = PF_WAIT_GNT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= PF_IDLE;
         abt_gnt_q    <= 1'b0;
         fetch_addr_q <= '0;
         req_addr_q   <= '0;
         addr_q       <= '0;
         is_hwlp_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         abt_gnt_q <= abt_gnt_d;
         if (redirect)   fetch_addr_q <= {target[31:2], 2'b00};
         else if (issue) fetch_addr_q <= fetch_addr_q + 32'd4;
         if (issue) req_addr_q <= fetch_addr_q;
         if (redirect) begin
            addr_q    <= target;
            is_hwlp_q <= hwlp_acc;
         end else if (consume) begin
            addr_q    <= addr_next;
            is_hwlp_q <= 1'b0;
         end
      end
   end

   assign hwlp_branch_o  = hwlp_acc;
   assign addr_o         = addr_q;
   assign is_hwlp_o      = is_hwlp_q;
   assign fetch_failed_o = (state_q == PF_FAILED);
   assign busy_o         = (state_q == PF_WAIT_GNT) || (state_q == PF_WAIT_RVALID) ||
                           (state_q == PF_WAIT_ABORTED);

endmodule

// File: tb/tb_riscv_prefetch_fifo_buffer.sv
// tb/tb_riscv_prefetch_fifo_buffer.sv - directed self-checking bench for the prefetcher
module tb_riscv_prefetch_fifo_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_i, branch_i, hwloop_i, ready_i;
   logic [31:0] addr_i, hwloop_target_i;
   logic        hwlp_branch_o, valid_o, is_hwlp_o;
   logic [31:0] rdata_o, addr_o, instr_addr_o;
   logic        instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_pmp_i;
   logic [31:0] instr_rdata_i;
   logic        fetch_failed_o, busy_o;

   int          checks = 0;
   int          failures = 0;

   bit          gnt_en = 1'b1;
   int          rvalid_delay = 1;
   bit          pmp_en = 1'b0;
   logic [31:0] pmp_addr = 32'h0;
   bit          pending = 1'b0;
   logic [31:0] pend_addr;
   int          pend_cnt;
   logic [31:0] gnt_log[$];

   always #5 clk = ~clk;

   riscv_prefetch_fifo_buffer #(.DEPTH(3), .RDATA_WIDTH(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_i           (req_i),
      .branch_i        (branch_i),
      .addr_i          (addr_i),
      .hwloop_i        (hwloop_i),
      .hwloop_target_i (hwloop_target_i),
      .hwlp_branch_o   (hwlp_branch_o),
      .ready_i         (ready_i),
      .valid_o         (valid_o),
      .rdata_o         (rdata_o),
      .addr_o          (addr_o),
      .is_hwlp_o       (is_hwlp_o),
      .instr_req_o     (instr_req_o),
      .instr_addr_o    (instr_addr_o),
      .instr_gnt_i     (instr_gnt_i),
      .instr_rvalid_i  (instr_rvalid_i),
      .instr_rdata_i   (instr_rdata_i),
      .instr_err_pmp_i (instr_err_pmp_i),
      .fetch_failed_o  (fetch_failed_o),
      .busy_o          (busy_o)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h100: return 32'h0000_0013;
         32'h104: return 32'h0010_0093;
         32'h200: return 32'h4505_0001;
         32'h300: return 32'h0513_0000;
         32'h304: return 32'h0000_0005;
         default: return (a << 8) | 32'h13;
      endcase
   endfunction

   function automatic logic [31:0] gnt_at(input int i);
      if (i < gnt_log.size()) return gnt_log[i];
      return 32'hxxxx_xxxx;
   endfunction

   // memory: grant in the request cycle, respond rvalid_delay cycles later
   initial begin
      instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_pmp_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         instr_rvalid_i = 1'b0;
         if (!rst_n) pending = 1'b0;
         else if (pending) begin
            if (pend_cnt <= 1) begin
               instr_rvalid_i = 1'b1;
               instr_rdata_i  = mem_word(pend_addr);
               pending        = 1'b0;
            end else pend_cnt--;
         end
         #1;
         instr_gnt_i = 1'b0; instr_err_pmp_i = 1'b0;
         if (rst_n && instr_req_o) begin
            if (pmp_en && instr_addr_o == pmp_addr) instr_err_pmp_i = 1'b1;
            else if (gnt_en) begin
               instr_gnt_i = 1'b1;
               pending     = 1'b1;
               pend_addr   = instr_addr_o;
               pend_cnt    = rvalid_delay;
               gnt_log.push_back(instr_addr_o);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [31:0] a);
      tick(); branch_i = 1'b1; addr_i = a;
      tick(); branch_i = 1'b0; gnt_log.delete();
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (valid_o) begin ok = 1'b1; break; end
      end
   endtask

   task automatic consume_one();
      tick(); ready_i = 1'b1;
      tick(); ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_i = 1'b0; branch_i = 1'b0; hwloop_i = 1'b0; ready_i = 1'b0;
      addr_i = '0; hwloop_target_i = '0;
      repeat (2) @(negedge clk);
      checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid_o); end
      checks++; if (addr_o !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", addr_o); end
      checks++; if (instr_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", instr_req_o); end
      checks++; if ({busy_o, fetch_failed_o, is_hwlp_o, hwlp_branch_o} !== 4'b0) begin
         failures++; $display("FAIL rst_flags got=%b exp=0000", {busy_o, fetch_failed_o, is_hwlp_o, hwlp_branch_o});
      end
      tick(); rst_n = 1'b1;
   endtask

   task automatic test_boot();
      bit ok;
      tick(); branch_i = 1'b1; addr_i = 32'h100; req_i = 1'b1;
      @(negedge clk);
      checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL boot_redirect_valid got=%b exp=0", valid_o); end
      tick(); branch_i = 1'b0; gnt_log.delete();
      wait_valid(ok);
      checks++; if (!ok) begin failures++; $display("FAIL boot_valid0 got=timeout exp=valid"); end
      checks++; if (addr_o !== 32'h100) begin failures++; $display("FAIL boot_addr0 got=%h exp=00000100", addr_o); end
      checks++; if (rdata_o !== 32'h0000_0013) begin failures++; $display("FAIL boot_rdata0 got=%h exp=00000013", rdata_o); end
      consume_one();
      wait_valid(ok);
      checks++; if (addr_o !== 32'h104) begin failures++; $display("FAIL boot_addr1 got=%h exp=00000104", addr_o); end
      checks++; if (rdata_o !== 32'h0010_0093) begin failures++; $display("FAIL boot_rdata1 got=%h exp=00100093", rdata_o); end
      checks++; if ({gnt_at(0), gnt_at(1), gnt_at(2)} !== {32'h100, 32'h104, 32'h108}) begin
         failures++; $display("FAIL boot_fetch_addrs got=%h %h %h exp=00000100 00000104 00000108", gnt_at(0), gnt_at(1), gnt_at(2));
      end
   endtask

   task automatic test_compressed();
      bit ok;
      redirect(32'h202);
      wait_valid(ok);
      checks++; if (addr_o !== 32'h202) begin failures++; $display("FAIL cmp_addr got=%h exp=00000202", addr_o); end
      checks++; if (rdata_o !== 32'h0000_4505) begin failures++; $display("FAIL cmp_rdata got=%h exp=00004505", rdata_o); end
      consume_one();
      wait_valid(ok);
      checks++; if (addr_o !== 32'h204) begin failures++; $display("FAIL cmp_next_addr got=%h exp=00000204", addr_o); end
      checks++; if (rdata_o !== 32'h0002_0413) begin failures++; $display("FAIL cmp_next_rdata got=%h exp=00020413", rdata_o); end
   endtask

   task automatic test_misaligned();
      bit ok, seen_rv;
      redirect(32'h302);
      seen_rv = 1'b0; ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         if (instr_rvalid_i && !seen_rv) begin
            seen_rv = 1'b1;
            checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL mis_one_word_valid got=%b exp=0", valid_o); end
         end else if (valid_o) ok = 1'b1;
      end
      checks++; if (!ok) begin failures++; $display("FAIL mis_valid got=timeout exp=valid"); end
      checks++; if (rdata_o !== 32'h0005_0513) begin failures++; $display("FAIL mis_rdata got=%h exp=00050513", rdata_o); end
      consume_one();
      wait_valid(ok);
      checks++; if (addr_o !== 32'h306) begin failures++; $display("FAIL mis_next_addr got=%h exp=00000306", addr_o); end
      checks++; if (rdata_o !== 32'h0000_0000) begin failures++; $display("FAIL mis_next_rdata got=%h exp=00000000", rdata_o); end
   endtask

   task automatic test_abort();
      bit ok, granted;
      rvalid_delay = 5;
      redirect(32'h100);
      granted = 1'b0;
      for (int i = 0; i < 10 && !granted; i++) begin
         @(negedge clk);
         if (gnt_log.size() != 0) granted = 1'b1;
      end
      checks++; if (!granted) begin failures++; $display("FAIL abort_gnt got=timeout exp=grant"); end
      tick(); branch_i = 1'b1; addr_i = 32'h400;
      tick(); branch_i = 1'b0; rvalid_delay = 1; gnt_log.delete();
      @(negedge clk);
      checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL abort_busy got=%b exp=1", busy_o); end
      wait_valid(ok);
      checks++; if (addr_o !== 32'h400) begin failures++; $display("FAIL abort_addr got=%h exp=00000400", addr_o); end
      checks++; if (rdata_o !== 32'h0004_0013) begin failures++; $display("FAIL abort_rdata got=%h exp=00040013", rdata_o); end
      checks++; if (gnt_at(0) !== 32'h400) begin failures++; $display("FAIL abort_refetch got=%h exp=00000400", gnt_at(0)); end
   endtask

   task automatic test_backpressure();
      redirect(32'h600);
      repeat (10) @(negedge clk);
      checks++; if (gnt_log.size() !== 3) begin failures++; $display("FAIL bp_fetches got=%0d exp=3", gnt_log.size()); end
      checks++; if (instr_req_o !== 1'b0) begin failures++; $display("FAIL bp_req got=%b exp=0", instr_req_o); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL bp_busy got=%b exp=0", busy_o); end
      consume_one();
      repeat (6) @(negedge clk);
      checks++; if (gnt_log.size() !== 4) begin failures++; $display("FAIL bp_refill got=%0d exp=4", gnt_log.size()); end
      checks++; if (gnt_at(3) !== 32'h60C) begin failures++; $display("FAIL bp_refill_addr got=%h exp=0000060c", gnt_at(3)); end
   endtask

   task automatic test_hwloop();
      bit ok;
      tick(); hwloop_i = 1'b1; hwloop_target_i = 32'h700;
      @(negedge clk);
      checks++; if (hwlp_branch_o !== 1'b1) begin failures++; $display("FAIL hwlp_taken got=%b exp=1", hwlp_branch_o); end
      tick(); hwloop_i = 1'b0;
      wait_valid(ok);
      checks++; if ({addr_o, is_hwlp_o} !== {32'h700, 1'b1}) begin
         failures++; $display("FAIL hwlp_first got=%h/%b exp=00000700/1", addr_o, is_hwlp_o);
      end
      consume_one();
      wait_valid(ok);
      checks++; if ({addr_o, is_hwlp_o} !== {32'h704, 1'b0}) begin
         failures++; $display("FAIL hwlp_second got=%h/%b exp=00000704/0", addr_o, is_hwlp_o);
      end
      tick(); branch_i = 1'b1; addr_i = 32'h740; hwloop_i = 1'b1; hwloop_target_i = 32'h780;
      @(negedge clk);
      checks++; if (hwlp_branch_o !== 1'b0) begin failures++; $display("FAIL hwlp_vs_branch got=%b exp=0", hwlp_branch_o); end
      tick(); branch_i = 1'b0; hwloop_i = 1'b0;
      wait_valid(ok);
      checks++; if ({addr_o, is_hwlp_o} !== {32'h740, 1'b0}) begin
         failures++; $display("FAIL hwlp_branch_prio got=%h/%b exp=00000740/0", addr_o, is_hwlp_o);
      end
   endtask

   task automatic test_pmp();
      bit ok, failed;
      pmp_en = 1'b1; pmp_addr = 32'h500;
      redirect(32'h500);
      failed = 1'b0;
      for (int i = 0; i < 10 && !failed; i++) begin
         @(negedge clk);
         if (fetch_failed_o) failed = 1'b1;
      end
      checks++; if (!failed) begin failures++; $display("FAIL pmp_failed got=0 exp=1"); end
      checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL pmp_valid got=%b exp=0", valid_o); end
      checks++; if (gnt_log.size() !== 0) begin failures++; $display("FAIL pmp_gnt got=%0d exp=0", gnt_log.size()); end
      tick(); hwloop_i = 1'b1; hwloop_target_i = 32'h900;
      @(negedge clk);
      checks++; if ({instr_req_o, hwlp_branch_o} !== 2'b00) begin
         failures++; $display("FAIL pmp_idle got=%b exp=00", {instr_req_o, hwlp_branch_o});
      end
      tick(); hwloop_i = 1'b0;
      @(negedge clk);
      checks++; if (fetch_failed_o !== 1'b1) begin failures++; $display("FAIL pmp_hwlp_ignored got=%b exp=1", fetch_failed_o); end
      pmp_en = 1'b0;
      redirect(32'h80);
      wait_valid(ok);
      checks++; if (fetch_failed_o !== 1'b0) begin failures++; $display("FAIL pmp_recover got=%b exp=0", fetch_failed_o); end
      checks++; if ({addr_o, rdata_o} !== {32'h80, 32'h0000_8013}) begin
         failures++; $display("FAIL pmp_refetch got=%h/%h exp=00000080/00008013", addr_o, rdata_o);
      end
      checks++; if (gnt_at(0) !== 32'h80) begin failures++; $display("FAIL pmp_fetch_addr got=%h exp=00000080", gnt_at(0)); end
   endtask

   task automatic test_wrap();
      bit ok;
      redirect(32'hFFFF_FFFC);
      wait_valid(ok);
      checks++; if (rdata_o !== 32'hFFFF_FC13) begin failures++; $display("FAIL wrap_rdata got=%h exp=fffffc13", rdata_o); end
      checks++; if ({gnt_at(0), gnt_at(1)} !== {32'hFFFF_FFFC, 32'h0}) begin
         failures++; $display("FAIL wrap_addrs got=%h %h exp=fffffffc 00000000", gnt_at(0), gnt_at(1));
      end
   endtask

   task automatic test_mid_reset();
      redirect(32'h900);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({valid_o, busy_o, addr_o} !== {1'b0, 1'b0, 32'h0}) begin
         failures++; $display("FAIL midrst got=%b/%b/%h exp=0/0/00000000", valid_o, busy_o, addr_o);
      end
      tick(); rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_boot();
      test_compressed();
      test_misaligned();
      test_abort();
      test_backpressure();
      test_hwloop();
      test_pmp();
      test_wrap();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
